// File: rtl/sram_axi_bridge_pkg.sv
// Shared encodings for the SRAM-to-AXI bridge: read/write FSM states and
// the fixed AXI transfer size used for instruction fetches.
package sram_axi_bridge_pkg;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_AR   = 2'd1,
        R_R    = 2'd2,
        R_DONE = 2'd3
    } rstate_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_REQ  = 2'd1,
        W_B    = 2'd2,
        W_DONE = 2'd3
    } wstate_t;

    localparam logic [2:0] SIZE_WORD = 3'b010;

endpackage

// File: rtl/sram_axi_bridge_if.sv
// Core-side SRAM ports plus the single-beat AXI master channel of the bridge.
// "master" is the bridge's view; "slave" is the surrounding core + AXI slave.
interface sram_axi_bridge_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [2:0]  arsize;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rready;

    logic [31:0] awaddr;
    logic [2:0]  awsize;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic        bvalid;
    logic        bready;

    modport master (
        input  inst_req, inst_addr,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata,
        output arid, araddr, arsize, arvalid, rready,
        input  arready, rdata, rvalid,
        output awaddr, awsize, awvalid, wdata, wstrb, wvalid, bready,
        input  awready, wready, bvalid
    );

    modport slave (
        output inst_req, inst_addr,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  arid, araddr, arsize, arvalid, rready,
        output arready, rdata, rvalid,
        input  awaddr, awsize, awvalid, wdata, wstrb, wvalid, bready,
        output awready, wready, bvalid
    );
endinterface

// File: rtl/sram_axi_bridge.sv
// Converts the core's instruction and data SRAM ports into one AXI master.
// Strictly one transaction in flight; the data port wins arbitration.
module sram_axi_bridge
    import sram_axi_bridge_pkg::*;
#(
    parameter logic [3:0] INST_ID = 4'd0,
    parameter logic [3:0] DATA_ID = 4'd1
) (
    input  logic              clk,
    input  logic              reset,
    sram_axi_bridge_if.master bus
);

    rstate_t rstate, rstate_nxt;
    wstate_t wstate, wstate_nxt;

    logic        idle, data_acc, inst_acc, rd_acc, wr_acc;
    logic        owner_data;
    logic        aw_done, w_done, aw_hs, w_hs;
    logic [3:0]  arid_q;
    logic [31:0] araddr_q, awaddr_q, wdata_q, inst_rdata_q, data_rdata_q;
    logic [2:0]  arsize_q, awsize_q;
    logic [3:0]  wstrb_q;

    // Serialisation: nothing new is accepted until both FSMs are back in IDLE,
    // which is what keeps loads after stores coherent.
    assign idle     = (rstate == R_IDLE) && (wstate == W_IDLE);
    assign data_acc = idle && bus.data_req;
    assign inst_acc = idle && bus.inst_req && !bus.data_req;
    assign rd_acc   = inst_acc || (data_acc && !bus.data_wr);
    assign wr_acc   = data_acc && bus.data_wr;

    assign bus.data_addr_ok = data_acc;
    assign bus.inst_addr_ok = inst_acc;

    assign bus.arvalid = (rstate == R_AR);
    assign bus.rready  = (rstate == R_R);
    assign bus.arid    = arid_q;
    assign bus.araddr  = araddr_q;
    assign bus.arsize  = arsize_q;

    assign bus.awvalid = (wstate == W_REQ) && !aw_done;
    assign bus.wvalid  = (wstate == W_REQ) && !w_done;
    assign bus.bready  = (wstate == W_B);
    assign bus.awaddr  = awaddr_q;
    assign bus.awsize  = awsize_q;
    assign bus.wdata   = wdata_q;
    assign bus.wstrb   = wstrb_q;

    assign aw_hs = bus.awvalid && bus.awready;
    assign w_hs  = bus.wvalid && bus.wready;

    assign bus.inst_data_ok = (rstate == R_DONE) && !owner_data;
    assign bus.data_data_ok = ((rstate == R_DONE) && owner_data) || (wstate == W_DONE);
    assign bus.inst_rdata   = inst_rdata_q;
    assign bus.data_rdata   = data_rdata_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rstate <= R_IDLE;
            wstate <= W_IDLE;
        end else begin
            rstate <= rstate_nxt;
            wstate <= wstate_nxt;
        end
    end

    always_comb begin
        rstate_nxt = rstate;
        unique case (rstate)
            R_IDLE: if (rd_acc)      rstate_nxt = R_AR;
            R_AR:   if (bus.arready) rstate_nxt = R_R;
            R_R:    if (bus.rvalid)  rstate_nxt = R_DONE;
            R_DONE:                  rstate_nxt = R_IDLE;
            default:                 rstate_nxt = R_IDLE;
        endcase
    end

    // A handshake in the current cycle counts as done, so W_B is entered on
    // the edge that completes the later of the two channels.
    always_comb begin
        wstate_nxt = wstate;
        unique case (wstate)
            W_IDLE: if (wr_acc) wstate_nxt = W_REQ;
            W_REQ:  if ((aw_done || aw_hs) && (w_done || w_hs)) wstate_nxt = W_B;
            W_B:    if (bus.bvalid) wstate_nxt = W_DONE;
            W_DONE:                 wstate_nxt = W_IDLE;
            default:                wstate_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else if (wstate == W_DONE) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_data   <= 1'b0;
            arid_q       <= 4'd0;
            araddr_q     <= 32'd0;
            arsize_q     <= 3'd0;
            inst_rdata_q <= 32'd0;
            data_rdata_q <= 32'd0;
        end else begin
            if (rd_acc) begin
                owner_data <= data_acc;
                arid_q     <= data_acc ? DATA_ID : INST_ID;
                araddr_q   <= data_acc ? bus.data_addr : bus.inst_addr;
                arsize_q   <= data_acc ? {1'b0, bus.data_size} : SIZE_WORD;
            end
            if ((rstate == R_R) && bus.rvalid) begin
                if (owner_data) data_rdata_q <= bus.rdata;
                else            inst_rdata_q <= bus.rdata;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            awaddr_q <= 32'd0;
            awsize_q <= 3'd0;
            wdata_q  <= 32'd0;
            wstrb_q  <= 4'd0;
        end else if (wr_acc) begin
            awaddr_q <= bus.data_addr;
            awsize_q <= {1'b0, bus.data_size};
            wdata_q  <= bus.data_wdata;
            wstrb_q  <= bus.data_wstrb;
        end
    end

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge: the bench plays both the core and a
// cycle-scripted AXI slave backed by a small word memory.
module tb_sram_axi_bridge;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [31:0] mem [logic [31:0]];

    sram_axi_bridge_if bus();

    sram_axi_bridge #(.INST_ID(4'd0), .DATA_ID(4'd1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Slave side of one read, entered in the cycle after acceptance (R_AR).
    task automatic axi_read(input int ar_wait, input logic [31:0] exp_addr,
                            input logic [3:0] exp_id, input logic [2:0] exp_size);
        for (int i = 0; i < ar_wait; i++) begin
            chk("stall_arvalid", bus.arvalid, 1'b1);
            chk("stall_araddr", bus.araddr, exp_addr);
            chk("stall_rready", bus.rready, 1'b0);
            chk("stall_daddr_ok", bus.data_addr_ok, 1'b0);
            chk("stall_iaddr_ok", bus.inst_addr_ok, 1'b0);
            tick();
        end
        chk("arvalid", bus.arvalid, 1'b1);
        chk("araddr", bus.araddr, exp_addr);
        chk("arid", bus.arid, exp_id);
        chk("arsize", bus.arsize, exp_size);
        chk("rready_pre", bus.rready, 1'b0);
        bus.arready = 1'b1;
        tick();
        bus.arready = 1'b0;
        chk("arvalid_drop", bus.arvalid, 1'b0);
        chk("rready", bus.rready, 1'b1);
        chk("r_daddr_ok", bus.data_addr_ok, 1'b0);
        chk("r_iaddr_ok", bus.inst_addr_ok, 1'b0);
        bus.rdata  = mem.exists(bus.araddr) ? mem[bus.araddr] : 32'h0;
        bus.rvalid = 1'b1;
        tick();
        bus.rvalid = 1'b0;
        bus.rdata  = 32'h0;
    endtask

    // Slave side of one write; W is accepted gap cycles before AW.
    task automatic axi_write(input int gap, input logic [31:0] exp_addr,
                             input logic [31:0] exp_data, input logic [3:0] exp_strb);
        chk("awvalid", bus.awvalid, 1'b1);
        chk("wvalid", bus.wvalid, 1'b1);
        chk("awaddr", bus.awaddr, exp_addr);
        chk("wdata", bus.wdata, exp_data);
        chk("wstrb", bus.wstrb, exp_strb);
        chk("awsize", bus.awsize, 3'b010);
        chk("bready_pre", bus.bready, 1'b0);
        mem[bus.awaddr] = bus.wdata;
        bus.wready = 1'b1;
        if (gap == 0) begin
            bus.awready = 1'b1;
            tick();
            bus.awready = 1'b0;
            bus.wready  = 1'b0;
        end else begin
            tick();
            bus.wready = 1'b0;
            for (int i = 1; i < gap; i++) begin
                chk("skew_wvalid", bus.wvalid, 1'b0);
                chk("skew_awvalid", bus.awvalid, 1'b1);
                chk("skew_bready", bus.bready, 1'b0);
                tick();
            end
            chk("skew_wvalid", bus.wvalid, 1'b0);
            chk("skew_awvalid", bus.awvalid, 1'b1);
            bus.awready = 1'b1;
            tick();
            bus.awready = 1'b0;
        end
        chk("bready", bus.bready, 1'b1);
        chk("aw_drop", bus.awvalid, 1'b0);
        chk("w_drop", bus.wvalid, 1'b0);
        chk("b_daddr_ok", bus.data_addr_ok, 1'b0);
        chk("b_ddata_ok", bus.data_data_ok, 1'b0);
        bus.bvalid = 1'b1;
        tick();
        bus.bvalid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.inst_req = 0; bus.inst_addr = 0;
        bus.data_req = 0; bus.data_wr = 0; bus.data_size = 0; bus.data_wstrb = 0;
        bus.data_addr = 0; bus.data_wdata = 0;
        bus.arready = 0; bus.rdata = 0; bus.rvalid = 0;
        bus.awready = 0; bus.wready = 0; bus.bvalid = 0;
        mem[32'h1c000000] = 32'h02800413;
        mem[32'h1c000004] = 32'h11111111;
        mem[32'h1c000008] = 32'h0badf00d;
        mem[32'h00000080] = 32'h000000a5;

        tick(); tick();
        chk("rst_arvalid", bus.arvalid, 1'b0);
        chk("rst_awvalid", bus.awvalid, 1'b0);
        chk("rst_rready", bus.rready, 1'b0);
        chk("rst_bready", bus.bready, 1'b0);
        chk("rst_araddr", bus.araddr, 32'h0);
        chk("rst_inst_rdata", bus.inst_rdata, 32'h0);
        reset = 1'b0;
        tick();

        // single instruction fetch
        bus.inst_req = 1; bus.inst_addr = 32'h1c000000; #1;
        chk("t1_iaddr_ok", bus.inst_addr_ok, 1'b1);
        chk("t1_daddr_ok", bus.data_addr_ok, 1'b0);
        tick();
        bus.inst_req = 0;
        axi_read(0, 32'h1c000000, 4'd0, 3'b010);
        chk("t1_idata_ok", bus.inst_data_ok, 1'b1);
        chk("t1_ddata_ok", bus.data_data_ok, 1'b0);
        chk("t1_irdata", bus.inst_rdata, 32'h02800413);
        tick();
        chk("t1_idata_ok_pulse", bus.inst_data_ok, 1'b0);
        chk("t1_irdata_hold", bus.inst_rdata, 32'h02800413);

        // simultaneous requests, data wins
        bus.inst_req = 1; bus.inst_addr = 32'h1c000004;
        bus.data_req = 1; bus.data_wr = 0; bus.data_addr = 32'h80; bus.data_size = 2'd0; #1;
        chk("t2_daddr_ok", bus.data_addr_ok, 1'b1);
        chk("t2_iaddr_ok", bus.inst_addr_ok, 1'b0);
        tick();
        bus.data_req = 0;
        axi_read(0, 32'h80, 4'd1, 3'b000);
        chk("t2_ddata_ok", bus.data_data_ok, 1'b1);
        chk("t2_idata_ok", bus.inst_data_ok, 1'b0);
        chk("t2_drdata", bus.data_rdata, 32'h000000a5);
        chk("t2_iaddr_ok_wait", bus.inst_addr_ok, 1'b0);
        tick();
        chk("t2_iaddr_ok", bus.inst_addr_ok, 1'b1);
        tick();
        bus.inst_req = 0;
        axi_read(0, 32'h1c000004, 4'd0, 3'b010);
        chk("t2_idata_ok", bus.inst_data_ok, 1'b1);
        chk("t2_irdata", bus.inst_rdata, 32'h11111111);
        tick();

        // store with W three cycles ahead of AW
        bus.data_req = 1; bus.data_wr = 1; bus.data_addr = 32'h100; bus.data_size = 2'd2;
        bus.data_wdata = 32'hdeadbeef; bus.data_wstrb = 4'b1111; #1;
        chk("t3_daddr_ok", bus.data_addr_ok, 1'b1);
        tick();
        bus.data_req = 0;
        axi_write(3, 32'h100, 32'hdeadbeef, 4'b1111);
        chk("t3_ddata_ok", bus.data_data_ok, 1'b1);
        chk("t3_idata_ok", bus.inst_data_ok, 1'b0);
        tick();
        chk("t3_ddata_ok_pulse", bus.data_data_ok, 1'b0);

        // read after write: load is held off until the store completes
        bus.data_req = 1; bus.data_wr = 1; bus.data_addr = 32'h200;
        bus.data_wdata = 32'h12345678; bus.data_wstrb = 4'b1111; #1;
        chk("t4_st_addr_ok", bus.data_addr_ok, 1'b1);
        tick();
        bus.data_wr = 0; bus.data_wdata = 0; #1;
        chk("t4_ld_withheld", bus.data_addr_ok, 1'b0);
        axi_write(0, 32'h200, 32'h12345678, 4'b1111);
        chk("t4_st_data_ok", bus.data_data_ok, 1'b1);
        chk("t4_ld_withheld_done", bus.data_addr_ok, 1'b0);
        tick();
        chk("t4_ld_addr_ok", bus.data_addr_ok, 1'b1);
        tick();
        bus.data_req = 0;
        axi_read(0, 32'h200, 4'd1, 3'b010);
        chk("t4_ld_data_ok", bus.data_data_ok, 1'b1);
        chk("t4_ld_rdata", bus.data_rdata, 32'h12345678);
        tick();

        // AR back-pressure with a competing data request pending
        bus.inst_req = 1; bus.inst_addr = 32'h1c000008; #1;
        chk("t5_iaddr_ok", bus.inst_addr_ok, 1'b1);
        tick();
        bus.inst_req = 0;
        bus.data_req = 1; bus.data_wr = 0; bus.data_addr = 32'h80; bus.data_size = 2'd2;
        axi_read(5, 32'h1c000008, 4'd0, 3'b010);
        chk("t5_idata_ok", bus.inst_data_ok, 1'b1);
        chk("t5_irdata", bus.inst_rdata, 32'h0badf00d);
        chk("t5_daddr_ok_wait", bus.data_addr_ok, 1'b0);
        tick();
        chk("t5_daddr_ok", bus.data_addr_ok, 1'b1);
        tick();
        bus.data_req = 0;
        axi_read(0, 32'h80, 4'd1, 3'b010);
        chk("t5_ddata_ok", bus.data_data_ok, 1'b1);
        chk("t5_drdata", bus.data_rdata, 32'h000000a5);
        tick();

        // reset while waiting for R
        bus.inst_req = 1; bus.inst_addr = 32'h1c000004;
        tick();
        bus.inst_req = 0;
        bus.arready = 1;
        tick();
        bus.arready = 0;
        chk("t6_in_r", bus.rready, 1'b1);
        reset = 1'b1; #1;
        chk("t6_arvalid", bus.arvalid, 1'b0);
        chk("t6_rready", bus.rready, 1'b0);
        chk("t6_idata_ok", bus.inst_data_ok, 1'b0);
        chk("t6_ddata_ok", bus.data_data_ok, 1'b0);
        chk("t6_araddr", bus.araddr, 32'h0);
        chk("t6_irdata", bus.inst_rdata, 32'h0);
        tick();
        reset = 1'b0;
        tick();
        bus.inst_req = 1; bus.inst_addr = 32'h1c000000; #1;
        chk("t6_iaddr_ok", bus.inst_addr_ok, 1'b1);
        tick();
        bus.inst_req = 0;
        axi_read(0, 32'h1c000000, 4'd0, 3'b010);
        chk("t6_idata_ok_after", bus.inst_data_ok, 1'b1);
        chk("t6_irdata_after", bus.inst_rdata, 32'h02800413);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sram_axi_bridge.md
Name: sram_axi_bridge

Overview:
- Sits directly downstream of the CPU core. It converts the core's SRAM-like instruction port (read-only) and data port (read/write) into one AXI master interface.
- The interface is single-beat. At most one transaction is in flight at any time.
- Read and write are handled by independent FSMs. A global serialisation rule preserves program order and read-after-write correctness.
- Constant AXI fields are tied off in the SoC wrapper: len=0, burst=01, lock/cache/prot=0, wlast=1, awid/wid=1.

Parameters:
- INST_ID, 4'd0, arid used for instruction reads
- DATA_ID, 4'd1, arid used for data reads

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
inst_req  in  1  instruction read request
inst_addr  in  32  instruction byte address (word-aligned)
inst_addr_ok  out  1  instruction request accepted this cycle
inst_data_ok  out  1  one-cycle pulse, inst_rdata valid
inst_rdata  out  32  instruction word
data_req  in  1  data request
data_wr  in  1  1=write, 0=read
data_size  in  2  0=byte, 1=half, 2=word
data_wstrb  in  4  byte enables for a write
data_addr  in  32  data byte address
data_wdata  in  32  store data
data_addr_ok  out  1  data request accepted this cycle
data_data_ok  out  1  one-cycle pulse, read data returned or write completed
data_rdata  out  32  load data
arid  out  4  read ID
araddr  out  32  read address
arsize  out  3  read size
arvalid  out  1  read address valid
arready  in  1  read address ready
rdata  in  32  read data
rvalid  in  1  read data valid
rready  out  1  read data ready
awaddr  out  32  write address
awsize  out  3  write size
awvalid  out  1  write address valid
awready  in  1  write address ready
wdata  out  32  write data
wstrb  out  4  write strobes
wvalid  out  1  write data valid
wready  in  1  write data ready
bvalid  in  1  write response valid
bready  out  1  write response ready

Behaviour:
- Reset (async, any time, including mid-transaction):
  - Both FSMs go to IDLE.
  - All valid, ready, addr_ok and data_ok outputs are 0.
  - The address, data and rdata registers are 0.
  - A transaction in flight is abandoned. The AXI slave is reset together with the bridge.
- Acceptance condition: idle = (rstate==R_IDLE) && (wstate==W_IDLE).
  - data_addr_ok = idle && data_req. The data port has priority.
  - inst_addr_ok = idle && inst_req && !data_req.
  - addr_ok is combinational. The request is latched on the same rising edge.
- Read FSM states: R_IDLE -> R_AR -> R_R -> R_DONE -> R_IDLE.
  - R_IDLE: on an accepted read, latch araddr, arid and arsize, plus owner (inst/data). Move to R_AR.
  - arsize is {1'b0, data_size} for data reads and 3'b010 for instruction reads.
  - R_AR: arvalid=1, with address fields held stable. On arready, move to R_R.
  - R_R: rready=1. On rvalid, capture rdata into the owner's rdata register and move to R_DONE. rid and rresp are ignored.
  - R_DONE: assert the owner's data_ok for exactly 1 cycle, then return to R_IDLE. rdata holds until the next capture.
  - Minimum latency from addr_ok to data_ok is 3 cycles, with arready and rvalid arriving as early as possible.
- Write FSM states: W_IDLE -> W_REQ -> W_B -> W_DONE -> W_IDLE.
  - W_IDLE: on an accepted data write, latch awaddr, wdata and wstrb. awsize is {1'b0, data_size}.
  - W_REQ: awvalid and wvalid are asserted together. Flags aw_done and w_done record each handshake independently.
  - Each valid drops on the cycle after its own handshake. Handshakes may occur in the same cycle or in either order.
  - When both flags are set, move to W_B.
  - W_B: bready=1. On bvalid, move to W_DONE. bresp is ignored.
  - W_DONE: data_data_ok=1 for 1 cycle, then return to W_IDLE with both flags cleared.
- Ordering:
  - No new request is accepted while any transaction is outstanding, so a load after a store always sees the stored data.
  - Requests held while not idle stay pending until accepted. The core must hold them stable.
- inst_data_ok and data_data_ok are never high in the same cycle.

Decomposition:
- Shared package holds:
  - Read FSM state encodings (R_IDLE, R_AR, R_R, R_DONE).
  - Write FSM state encodings (W_IDLE, W_REQ, W_B, W_DONE).
  - The AXI size constant SIZE_WORD=3'b010.
- No sub-module is needed. The two FSMs and the arbitration logic live in one file.

Test Plan:
- Single instruction read: inst_req=1, addr=0x1c000000. Slave: arready=1 immediately, rdata=0x02800413 one cycle later. Required: inst_addr_ok in cycle 0, arvalid held until the handshake with arid=0, inst_data_ok pulses once, inst_rdata=0x02800413.
- Simultaneous requests: inst_req and data_req (read, addr 0x80, size 0) asserted together. Required: data accepted first with arsize=0 and arid=1. Inst is accepted only after data_data_ok.
- Store with AW/W skew: write addr 0x100, wdata 0xdeadbeef, wstrb 4'b1111. Slave: wready 3 cycles before awready. Required: wvalid drops after its handshake, awvalid persists, data_data_ok pulses 1 cycle after bvalid.
- Read after write: store 0x12345678 to 0x200, then a load from 0x200 requested the next cycle. Required: the load's addr_ok is withheld until the store's data_ok. The load returns 0x12345678.
- Back-pressure: arready=0 for 5 cycles. Required: arvalid and araddr stay stable, no addr_ok is issued, and rready=0 until the AR handshake.
- Reset mid-read: assert reset while in R_R. Required: arvalid, rready and data_ok are 0 immediately. After release, a fresh inst read completes normally.
